// File: rtl/pl_io_bank_if.sv
// User-I/O bundle between the board pins / core registers and pl_io_bank.
// master drives raw inputs and configuration; slave (pl_io_bank) returns the conditioned I/O state.
interface pl_io_bank_if #(
   parameter int NR_OF_BUTTONS_P  = 4,
   parameter int NR_OF_SWITCHES_P = 2,
   parameter int NR_OF_LEDS_P     = 4,
   parameter int CNT_WIDTH_P      = 32
);
   logic [NR_OF_BUTTONS_P-1:0]              btn_in;
   logic [NR_OF_SWITCHES_P-1:0]             sw_in;
   logic [2*NR_OF_LEDS_P-1:0]               led_mode;
   logic [CNT_WIDTH_P*NR_OF_LEDS_P-1:0]     led_half_period;
   logic [NR_OF_BUTTONS_P-1:0]              irq_clr;

   logic [NR_OF_BUTTONS_P-1:0]              btn_level;
   logic [NR_OF_BUTTONS_P-1:0]              btn_press;
   logic [NR_OF_BUTTONS_P-1:0]              btn_tgl;
   logic [NR_OF_SWITCHES_P-1:0]             sw_out;
   logic [NR_OF_LEDS_P-1:0]                 led_out;
   logic [NR_OF_BUTTONS_P-1:0]              btn_irq_pending;
   logic                                    irq;

   modport master (
      output btn_in, sw_in, led_mode, led_half_period, irq_clr,
      input  btn_level, btn_press, btn_tgl, sw_out, led_out, btn_irq_pending, irq
   );

   modport slave (
      input  btn_in, sw_in, led_mode, led_half_period, irq_clr,
      output btn_level, btn_press, btn_tgl, sw_out, led_out, btn_irq_pending, irq
   );
endinterface

// File: rtl/pl_io_bank.sv
// Parametrised PL user-I/O: synchronised switches, debounced buttons, per-LED mode engine.
// Define PL_IO_BANK_IRQ_EN to build the sticky press-pending bits and the irq line.
//
// LED mode   | meaning
// LED_OFF    | led_out low, counter parked at 0
// LED_ON     | led_out high, counter parked at 0
// LED_BLINK  | counter runs up, led_out flips every effective half period
// LED_FLASH  | press loads counter, led_out high until it counts down to 0
module pl_io_bank #(
   parameter int NR_OF_BUTTONS_P   = 4,
   parameter int NR_OF_SWITCHES_P  = 2,
   parameter int NR_OF_LEDS_P      = 4,
   parameter int SYNC_STAGES_P     = 2,
   parameter int DEBOUNCE_CYCLES_P = 1250000,
   parameter int CNT_WIDTH_P       = 32
) (
   input  logic        clk,
   input  logic        rst,
   pl_io_bank_if.slave io
);
   localparam int N    = NR_OF_BUTTONS_P;
   localparam int M    = NR_OF_SWITCHES_P;
   localparam int L    = NR_OF_LEDS_P;
   localparam int S    = SYNC_STAGES_P;
   localparam int CW   = CNT_WIDTH_P;
   localparam int DB_W = (DEBOUNCE_CYCLES_P > 1) ? $clog2(DEBOUNCE_CYCLES_P) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES_P - 1);

   typedef enum logic [1:0] {
      LED_OFF   = 2'b00,
      LED_ON    = 2'b01,
      LED_BLINK = 2'b10,
      LED_FLASH = 2'b11
   } led_mode_e;

   logic [S-1:0][M-1:0] sw_sync;
   logic [S-1:0][N-1:0] btn_sync;
   logic [N-1:0]        btn_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_sync  <= '0;
         btn_sync <= '0;
      end else begin
         sw_sync[0]  <= io.sw_in;
         btn_sync[0] <= io.btn_in;
         for (int k = 1; k < S; k++) begin
            sw_sync[k]  <= sw_sync[k-1];
            btn_sync[k] <= btn_sync[k-1];
         end
      end
   end

   assign btn_s = btn_sync[S-1];

   logic [N-1:0][DB_W-1:0] db_cnt;
   logic [N-1:0]           btn_level;
   logic [N-1:0]           btn_press;
   logic [N-1:0]           btn_tgl;

   // The counter only runs while the synced input disagrees with the accepted level,
   // so any glitch shorter than the debounce window collapses back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt    <= '0;
         btn_level <= '0;
         btn_press <= '0;
         btn_tgl   <= '0;
      end else begin
         btn_press <= '0;
         for (int i = 0; i < N; i++) begin
            if (btn_s[i] != btn_level[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_cnt[i]    <= '0;
                  btn_level[i] <= btn_s[i];
                  if (btn_s[i]) begin
                     btn_press[i] <= 1'b1;
                     btn_tgl[i]   <= ~btn_tgl[i];
                  end
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   led_mode_e            led_mode_d [L];
   led_mode_e            led_mode_q [L];
   logic [L-1:0][CW-1:0] eff_half;
   logic [L-1:0][CW-1:0] eff_last;
   logic [L-1:0][CW-1:0] led_cnt;
   logic [L-1:0]         flash_trig;
   logic [L-1:0]         led_q;

   always_comb begin
      eff_half   = '0;
      eff_last   = '0;
      flash_trig = '0;
      for (int i = 0; i < L; i++) begin
         led_mode_d[i] = led_mode_e'(io.led_mode[2*i +: 2]);
         eff_half[i]   = (io.led_half_period[i*CW +: CW] == '0) ? CW'(1)
                                                                : io.led_half_period[i*CW +: CW];
         eff_last[i]   = eff_half[i] - CW'(1);
         flash_trig[i] = btn_press[i % N];
      end
   end

   // Entry into BLINK/FLASH is detected against last cycle's mode so no counter state carries over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            led_mode_q[i] <= LED_OFF;
         end
         led_cnt <= '0;
         led_q   <= '0;
      end else begin
         for (int i = 0; i < L; i++) begin
            led_mode_q[i] <= led_mode_d[i];
            unique case (led_mode_d[i])
               LED_OFF: begin
                  led_q[i]   <= 1'b0;
                  led_cnt[i] <= '0;
               end
               LED_ON: begin
                  led_q[i]   <= 1'b1;
                  led_cnt[i] <= '0;
               end
               LED_BLINK: begin
                  if (led_mode_q[i] != LED_BLINK) begin
                     led_q[i]   <= 1'b1;
                     led_cnt[i] <= '0;
                  end else if (led_cnt[i] >= eff_last[i]) begin
                     led_q[i]   <= ~led_q[i];
                     led_cnt[i] <= '0;
                  end else begin
                     led_cnt[i] <= led_cnt[i] + CW'(1);
                  end
               end
               LED_FLASH: begin
                  if (flash_trig[i]) begin
                     led_q[i]   <= 1'b1;
                     led_cnt[i] <= eff_half[i];
                  end else if (led_mode_q[i] != LED_FLASH) begin
                     led_q[i]   <= 1'b0;
                     led_cnt[i] <= '0;
                  end else if (led_cnt[i] != '0) begin
                     led_q[i]   <= (led_cnt[i] > CW'(1));
                     led_cnt[i] <= led_cnt[i] - CW'(1);
                  end else begin
                     led_q[i] <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

`ifdef PL_IO_BANK_IRQ_EN
   logic [N-1:0] irq_pending_q;
   logic         irq_q;

   // A press landing in the same cycle as its clear keeps the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_pending_q <= '0;
         irq_q         <= 1'b0;
      end else begin
         irq_pending_q <= (irq_pending_q & ~io.irq_clr) | btn_press;
         irq_q         <= |irq_pending_q;
      end
   end

   assign io.btn_irq_pending = irq_pending_q;
   assign io.irq             = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr     = ^io.irq_clr;
   assign io.btn_irq_pending = '0;
   assign io.irq             = 1'b0;
`endif

   assign io.btn_level = btn_level;
   assign io.btn_press = btn_press;
   assign io.btn_tgl   = btn_tgl;
   assign io.sw_out    = sw_sync[S-1];
   assign io.led_out   = led_q;
endmodule

// File: doc/pl_io_bank.md
Name: pl_io_bank

Overview:
Parametrised PL user-I/O block that generalises the fixed board I/O logic (2-stage switch sync, 3 toggling buttons, 1 blinking LED) to N buttons, M switches and L LEDs on one clock. Buttons are synchronised and debounced, and produce press pulses, toggles and optional sticky IRQs. Switches are synchronised. Each LED is driven by a per-LED mode: off, on, blink with a programmable period, or flash on a button press. It sits beside the core and feeds the configuration registers and the IRQ lines.

Parameters:
NR_OF_BUTTONS_P, 4, number of button inputs N (1..16)
NR_OF_SWITCHES_P, 2, number of switch inputs M (1..16)
NR_OF_LEDS_P, 4, number of LED outputs L (1..16)
SYNC_STAGES_P, 2, synchroniser flop stages (>=2)
DEBOUNCE_CYCLES_P, 1250000, consecutive stable cycles needed to accept a button change (10 ms at 125 MHz; >=1)
CNT_WIDTH_P, 32, width of LED period counters and period inputs

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
btn_in  input  N  raw buttons
sw_in  input  M  raw switches
btn_level  output  N  debounced button level
btn_press  output  N  1-cycle pulse on debounced rising edge
btn_tgl  output  N  toggles on each press
sw_out  output  M  synchronised switches
led_mode  input  2*L  per-LED mode; bits [2i+1:2i] belong to LED i
led_half_period  input  CNT_WIDTH_P*L  per-LED half period in clk cycles
led_out  output  L  LED drive
irq_clr  input  N  write-1-to-clear of pending bits
btn_irq_pending  output  N  sticky press flags
irq  output  1  OR of btn_irq_pending

Behaviour:
- Reset: the clock is clk and the reset is rst, asynchronous and active-high. While rst is high, all flops are cleared: sync chains, debounce counters, btn_level, btn_press, btn_tgl, sw_out, led_out, LED counters, btn_irq_pending and irq are all 0. Asserting rst mid-operation aborts every counter immediately.
- Switch path: SYNC_STAGES_P flop chain. sw_out equals sw_in delayed by SYNC_STAGES_P cycles. No debounce.
- Button path: a SYNC_STAGES_P chain feeds a debounce counter per button.
  - If synced != btn_level, the counter increments; otherwise it is cleared to 0.
  - When the counter reaches DEBOUNCE_CYCLES_P-1 while still unequal, btn_level takes the synced value on the next edge and the counter clears.
  - A clean input edge reaches btn_level exactly SYNC_STAGES_P+DEBOUNCE_CYCLES_P cycles later.
  - Any glitch shorter than DEBOUNCE_CYCLES_P cycles restarts the count and produces no change.
- btn_press is asserted for 1 cycle in the same cycle btn_level goes 0->1; btn_tgl inverts in that cycle. Falling edges produce no pulse.
- LED modes (registered; led_out responds 1 cycle after a mode or input change):
  - 00 OFF: led_out=0, counter held at 0.
  - 01 ON: led_out=1, counter held at 0.
  - 10 BLINK: on entry the counter=0 and led_out=1. The counter increments each cycle; when counter >= effective_half-1, led_out inverts and the counter wraps to 0. effective_half = max(led_half_period,1), so 0 or 1 toggles every cycle. The >= compare means that shrinking the period below the current count toggles on the next cycle and never wraps past 2^CNT_WIDTH_P.
  - 11 FLASH: a btn_press on button (i mod N) sets led_out=1 and loads the counter with effective_half. The counter decrements each cycle; led_out=0 when it reaches 0. A press during an active flash reloads the counter (retrigger).
- Mode change from any mode to another: the new mode's entry rule applies in the next cycle; there is no carry-over of counter state.
- IRQ (when enabled):
  - btn_press[j] sets btn_irq_pending[j]; irq_clr[j] clears it.
  - If press and clear occur in the same cycle, set wins.
  - irq is registered and equals |btn_irq_pending, 1 cycle after the pending bits.

Optional Feature:
PL_IO_BANK_IRQ_EN
- Defined: sticky pending bits and irq are implemented as described above.
- Undefined: btn_irq_pending and irq are tied to 0, irq_clr is ignored, and no pending flops are synthesised. All other behaviour is unchanged.

Test Plan:
All scenarios use N=4, M=2, L=4, SYNC_STAGES_P=2, DEBOUNCE_CYCLES_P=4, CNT_WIDTH_P=8.
- Reset value: drive rst=1 mid-blink -> all outputs 0 in the same cycle; after release with led_mode=0, outputs stay 0.
- Debounce timing: btn_in[1] clean 0->1 at cycle t -> btn_level[1]=1 at t+6, btn_press[1]=1 for exactly cycle t+6, btn_tgl[1]=1. A 3-cycle glitch on btn_in[0] -> no change on any output.
- Blink: led_mode[1:0]=10, led_half_period[7:0]=3 -> led_out[0] is 1,1,1,0,0,0,1... Change the period to 1 when the counter=2 -> toggle on the next cycle, then every cycle. Period 0 -> toggle every cycle.
- Flash: led_mode[3:2]=11, half=5, press btn 1 -> led_out[1] high 5 cycles. A second press at cycle 3 of the flash -> high 5 more cycles from the retrigger.
- IRQ (macro defined): press btn 2 -> btn_irq_pending=4'b0100, irq=1 one cycle later. irq_clr[2] with a simultaneous new press -> pending stays 1. irq_clr[2] alone -> irq=0 after 1 cycle. Macro undefined -> irq is always 0.
- Switch sync: toggle sw_in[1] -> sw_out[1] follows 2 cycles later with no debounce.
